// File: rtl/fpu_thread_sched_n_if.sv
// Scheduler <-> IU/FPU signal bundle: thread requests and stalls, FPU stage write enables in;
// issue grant, per-stage thread tags and per-thread demuxed enables/stalls out.
interface fpu_thread_sched_n_if #(
    parameter int NT = 4
);
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;

    logic          en;
    logic [NT-1:0] fasmds;
    logic [NT-1:0] st;
    logic          stall_div_sqrt;
    logic          e1w;
    logic          e2w;
    logic          e3w;
    logic          ww;

    logic [NT-1:0] gnt;
    logic          gnt_v;
    logic [TW-1:0] dt;
    logic [TW-1:0] e1t;
    logic [TW-1:0] e2t;
    logic [TW-1:0] e3t;
    logic [TW-1:0] wt;
    logic [NT-1:0] e1w_t;
    logic [NT-1:0] e2w_t;
    logic [NT-1:0] e3w_t;
    logic [NT-1:0] ww_t;
    logic [NT-1:0] stall_t;

    modport master (
        output en, fasmds, st, stall_div_sqrt, e1w, e2w, e3w, ww,
        input  gnt, gnt_v, dt, e1t, e2t, e3t, wt,
        input  e1w_t, e2w_t, e3w_t, ww_t, stall_t
    );

    modport slave (
        input  en, fasmds, st, stall_div_sqrt, e1w, e2w, e3w, ww,
        output gnt, gnt_v, dt, e1t, e2t, e3t, wt,
        output e1w_t, e2w_t, e3w_t, ww_t, stall_t
    );
endinterface

// File: rtl/fpu_thread_sched_n.sv
// Shared-FPU issue scheduler for NT threads: round-robin grant (FPU_SCHED_FIXED_PRIO_EN selects fixed priority),
// latency: grant zero-cycle, tag reaches E1/E2/E3/WB 1/2/3/4 advancing cycles later;
// backpressure: en=0 freezes the tag pipe and blocks grants, stalled (st) threads are skipped.
module fpu_thread_sched_n #(
    parameter int NT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    fpu_thread_sched_n_if.slave sif
);
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;

    logic [NT-1:0] elig;
    logic          found;
    logic [TW-1:0] win;

    logic [TW-1:0] e1t_q, e2t_q, e3t_q, wt_q;
    logic          e1v_q, e2v_q, e3v_q, wv_q;

    logic [NT-1:0] e1w_t, e2w_t, e3w_t, ww_t, stall_t;

    assign elig = sif.en ? (sif.fasmds & ~sif.st) : '0;

`ifdef FPU_SCHED_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NT; k++) begin
            if (!found && elig[TW'(k)]) begin
                found = 1'b1;
                win   = TW'(k);
            end
        end
    end
`else
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    int            cand;

    // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 0; k < NT; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NT) begin
                cand = cand - NT;
            end
            if (!found && elig[TW'(cand)]) begin
                found = 1'b1;
                win   = TW'(cand);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (sif.gnt_v) begin
            rr_ptr_d = (win == TW'(NT - 1)) ? '0 : win + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign sif.gnt_v = found & rst_n;
    assign sif.gnt   = sif.gnt_v ? (NT'(1) << win) : '0;
    assign sif.dt    = sif.gnt_v ? win : '0;

    // Tags ride alongside the FPU pipe and freeze with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1t_q <= '0;
            e2t_q <= '0;
            e3t_q <= '0;
            wt_q  <= '0;
            e1v_q <= 1'b0;
            e2v_q <= 1'b0;
            e3v_q <= 1'b0;
            wv_q  <= 1'b0;
        end else if (sif.en) begin
            e1t_q <= sif.dt;
            e1v_q <= sif.gnt_v;
            e2t_q <= e1t_q;
            e2v_q <= e1v_q;
            e3t_q <= e2t_q;
            e3v_q <= e2v_q;
            wt_q  <= e3t_q;
            wv_q  <= e3v_q;
        end
    end

    always_comb begin
        e1w_t   = '0;
        e2w_t   = '0;
        e3w_t   = '0;
        ww_t    = '0;
        stall_t = '0;
        for (int i = 0; i < NT; i++) begin
            e1w_t[i] = sif.e1w & e1v_q & (e1t_q == TW'(i));
            e2w_t[i] = sif.e2w & e2v_q & (e2t_q == TW'(i));
            e3w_t[i] = sif.e3w & e3v_q & (e3t_q == TW'(i));
            ww_t[i]  = sif.ww  & wv_q  & (wt_q  == TW'(i));
            // Only threads with an FP op waiting or still ahead of WB are held by div/sqrt.
            stall_t[i] = sif.stall_div_sqrt &
                         (sif.fasmds[i] |
                          (e1v_q & (e1t_q == TW'(i))) |
                          (e2v_q & (e2t_q == TW'(i))) |
                          (e3v_q & (e3t_q == TW'(i))));
        end
    end

    assign sif.e1t     = e1t_q;
    assign sif.e2t     = e2t_q;
    assign sif.e3t     = e3t_q;
    assign sif.wt      = wt_q;
    assign sif.e1w_t   = e1w_t;
    assign sif.e2w_t   = e2w_t;
    assign sif.e3w_t   = e3w_t;
    assign sif.ww_t    = ww_t;
    assign sif.stall_t = stall_t;
endmodule
